// File: rtl/calc_pkg.sv
// Shared definitions for the calc_sequencer block: widths, FSM state encoding
// and status bit positions.
package calc_pkg;

  localparam int unsigned OP_W     = 4;
  localparam int unsigned DATA_W   = 8;
  localparam int unsigned STATUS_W = 4;
  localparam int unsigned CNT_W    = 8;
  localparam int unsigned OPCNT_W  = 3;

  localparam int unsigned ST_TIMEOUT = 0;
  localparam int unsigned ST_BUSY    = 1;
  localparam int unsigned ST_VALID   = 2;
  localparam int unsigned ST_DROP    = 3;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_A = 3'd1,
    LOAD_B = 3'd2,
    EXEC   = 3'd3,
    OUTPUT = 3'd4
  } state_t;

endpackage

// File: rtl/calc_wait_timer.sv
// Operand wait counter: counts idle cycles in a load state and flags the
// cycle in which the timeout fires (never when a byte arrives that cycle).
module calc_wait_timer
  import calc_pkg::*;
#(
  parameter logic [CNT_W-1:0] TIMEOUT_CYCLES = 8'd200
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_active,
  input  logic i_data_valid,
  output logic o_timeout_c
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_active && !i_data_valid) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  // A zero limit disables the timeout entirely.
  assign o_timeout_c = (TIMEOUT_CYCLES != '0) && i_active && !i_data_valid &&
                       (r_count == TIMEOUT_CYCLES - CNT_W'(1));

endmodule

// File: rtl/calc_sequencer.sv
// Sequences an external ALU: load op code, two operand bytes, capture the
// result and hold it on the bus until the consumer accepts it.
module calc_sequencer
  import calc_pkg::*;
#(
  parameter logic [CNT_W-1:0] TIMEOUT_CYCLES = 8'd200
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [OP_W-1:0]     op_in,
  input  logic [DATA_W-1:0]   data_in,
  input  logic                data_valid,
  input  logic                result_ready,
  input  logic [DATA_W-1:0]   alu_y,
  output logic [OP_W-1:0]     alu_sel,
  output logic [DATA_W-1:0]   alu_a,
  output logic [DATA_W-1:0]   alu_b,
  output logic [DATA_W-1:0]   data_out,
  output logic [DATA_W-1:0]   data_oe,
  output logic                result_valid,
  output logic [STATUS_W-1:0] status,
  output logic [OPCNT_W-1:0]  op_count
);

  state_t r_state;
  state_t w_next;

  logic w_ld_sel, w_ld_a, w_ld_b, w_ld_out, w_done, w_timeout, w_drop;
  logic w_clear, w_active, w_timeout_c;

  logic [OP_W-1:0]    r_alu_sel;
  logic [DATA_W-1:0]  r_alu_a, r_alu_b, r_data_out, r_data_oe;
  logic               r_result_valid, r_busy, r_timeout, r_drop;
  logic [OPCNT_W-1:0] r_op_count;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_ld_sel  = 1'b0;
    w_ld_a    = 1'b0;
    w_ld_b    = 1'b0;
    w_ld_out  = 1'b0;
    w_done    = 1'b0;
    w_timeout = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_next   = LOAD_A;
          w_ld_sel = 1'b1;
        end
      end
      LOAD_A: begin
        if (data_valid) begin
          w_next = LOAD_B;
          w_ld_a = 1'b1;
        end else if (w_timeout_c) begin
          w_next    = IDLE;
          w_timeout = 1'b1;
        end
      end
      LOAD_B: begin
        if (data_valid) begin
          w_next = EXEC;
          w_ld_b = 1'b1;
        end else if (w_timeout_c) begin
          w_next    = IDLE;
          w_timeout = 1'b1;
        end
      end
      EXEC: begin
        w_next   = OUTPUT;
        w_ld_out = 1'b1;
      end
      OUTPUT: begin
        if (result_ready) begin
          w_next = IDLE;
          w_done = 1'b1;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  assign w_drop   = start && (r_state != IDLE);
  assign w_active = (r_state == LOAD_A) || (r_state == LOAD_B);
  // Restart the wait count on every entry into a load state.
  assign w_clear  = (w_next != r_state) && ((w_next == LOAD_A) || (w_next == LOAD_B));

  calc_wait_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clk          (clk),
    .rst          (rst),
    .i_clear      (w_clear),
    .i_active     (w_active),
    .i_data_valid (data_valid),
    .o_timeout_c  (w_timeout_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_alu_sel      <= '0;
      r_alu_a        <= '0;
      r_alu_b        <= '0;
      r_data_out     <= '0;
      r_data_oe      <= '0;
      r_result_valid <= 1'b0;
      r_busy         <= 1'b0;
      r_timeout      <= 1'b0;
      r_drop         <= 1'b0;
      r_op_count     <= '0;
    end else begin
      if (w_ld_sel) r_alu_sel  <= op_in;
      if (w_ld_a)   r_alu_a    <= data_in;
      if (w_ld_b)   r_alu_b    <= data_in;
      if (w_ld_out) r_data_out <= alu_y;
      if (w_done)   r_op_count <= r_op_count + OPCNT_W'(1);

      if (w_ld_sel)       r_timeout <= 1'b0;
      else if (w_timeout) r_timeout <= 1'b1;

      if (w_ld_sel)    r_drop <= 1'b0;
      else if (w_drop) r_drop <= 1'b1;

      // Bus-facing flags registered from the next state so they track it exactly.
      r_result_valid <= (w_next == OUTPUT);
      r_busy         <= (w_next != IDLE);
      r_data_oe      <= (w_next == OUTPUT) ? '1 : '0;
    end
  end

  assign alu_sel      = r_alu_sel;
  assign alu_a        = r_alu_a;
  assign alu_b        = r_alu_b;
  assign data_out     = r_data_out;
  assign data_oe      = r_data_oe;
  assign result_valid = r_result_valid;
  assign op_count     = r_op_count;

  assign status[ST_TIMEOUT] = r_timeout;
  assign status[ST_BUSY]    = r_busy;
  assign status[ST_VALID]   = r_result_valid;
  assign status[ST_DROP]    = r_drop;

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed bench for calc_sequencer with a small behavioural ALU model.
module tb_calc_sequencer;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] op_in;
  logic [7:0] data_in;
  logic       data_valid;
  logic       result_ready;
  logic [7:0] alu_y;
  logic [3:0] alu_sel;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [7:0] data_out;
  logic [7:0] data_oe;
  logic       result_valid;
  logic [3:0] status;
  logic [2:0] op_count;

  int n_vec;
  int n_err;

  logic [3:0] t_op [8] = '{4'd2, 4'd0, 4'd1, 4'd3, 4'd2, 4'd4, 4'd2, 4'd3};
  logic [7:0] t_a  [8] = '{8'h0F, 8'hF0, 8'h0C, 8'h10, 8'hFF, 8'hAA, 8'h80, 8'h05};
  logic [7:0] t_b  [8] = '{8'h01, 8'h3C, 8'h30, 8'h01, 8'h01, 8'h55, 8'h80, 8'h06};
  logic [7:0] t_y  [8] = '{8'h10, 8'h30, 8'h3C, 8'h0F, 8'h00, 8'hFF, 8'h00, 8'hFF};

  calc_sequencer #(
    .TIMEOUT_CYCLES (8'd4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .op_in        (op_in),
    .data_in      (data_in),
    .data_valid   (data_valid),
    .result_ready (result_ready),
    .alu_y        (alu_y),
    .alu_sel      (alu_sel),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .data_out     (data_out),
    .data_oe      (data_oe),
    .result_valid (result_valid),
    .status       (status),
    .op_count     (op_count)
  );

  // External ALU model
  always_comb begin
    case (alu_sel)
      4'd0:    alu_y = alu_a & alu_b;
      4'd1:    alu_y = alu_a | alu_b;
      4'd2:    alu_y = alu_a + alu_b;
      4'd3:    alu_y = alu_a - alu_b;
      default: alu_y = alu_a ^ alu_b;
    endcase
  end

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (observed timeout, expected completion)");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Start an operation and run it up to OUTPUT, checking each step.
  task automatic load_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] y);
    start = 1'b1;
    op_in = op;
    tick();
    start = 1'b0;
    chk("load_a_sel", 32'(alu_sel), 32'(op));
    chk("load_a_status", 32'(status), 32'h2);
    data_valid = 1'b1;
    data_in    = a;
    tick();
    chk("load_b_alu_a", 32'(alu_a), 32'(a));
    data_in = b;
    tick();
    data_valid = 1'b0;
    chk("exec_alu_b", 32'(alu_b), 32'(b));
    chk("exec_rv", 32'(result_valid), 32'h0);
    chk("exec_status", 32'(status), 32'h2);
    tick();
    chk("out_data", 32'(data_out), 32'(y));
    chk("out_rv", 32'(result_valid), 32'h1);
    chk("out_oe", 32'(data_oe), 32'hFF);
    chk("out_status_low", 32'(status[2:0]), 32'h6);
  endtask

  task automatic finish_op(input logic [2:0] cnt);
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    chk("done_count", 32'(op_count), 32'(cnt));
    chk("done_rv", 32'(result_valid), 32'h0);
    chk("done_oe", 32'(data_oe), 32'h0);
    chk("done_busy", 32'(status[1]), 32'h0);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_sel"},    32'(alu_sel), 32'h0);
    chk({tag, "_a"},      32'(alu_a), 32'h0);
    chk({tag, "_b"},      32'(alu_b), 32'h0);
    chk({tag, "_dout"},   32'(data_out), 32'h0);
    chk({tag, "_oe"},     32'(data_oe), 32'h0);
    chk({tag, "_rv"},     32'(result_valid), 32'h0);
    chk({tag, "_status"}, 32'(status), 32'h0);
    chk({tag, "_count"},  32'(op_count), 32'h0);
  endtask

  initial begin
    n_vec        = 0;
    n_err        = 0;
    clk          = 1'b0;
    rst          = 1'b1;
    start        = 1'b0;
    op_in        = 4'h0;
    data_in      = 8'h00;
    data_valid   = 1'b0;
    result_ready = 1'b0;
    tick();
    tick();
    chk_reset_values("reset");
    rst = 1'b0;

    // Stray data_valid / result_ready in IDLE are ignored
    data_valid   = 1'b1;
    data_in      = 8'h55;
    result_ready = 1'b1;
    tick();
    data_valid   = 1'b0;
    result_ready = 1'b0;
    chk("idle_ign_a", 32'(alu_a), 32'h0);
    chk("idle_ign_status", 32'(status), 32'h0);
    chk("idle_ign_count", 32'(op_count), 32'h0);

    // Reset while holding a result in OUTPUT
    load_op(4'd2, 8'h0F, 8'h01, 8'h10);
    start = 1'b1;
    op_in = 4'd9;
    tick();
    start = 1'b0;
    chk("out_drop_status", 32'(status), 32'hE);
    chk("out_drop_sel", 32'(alu_sel), 32'h2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset_values("rst_out");
    tick();
    chk("rst_out_idle_status", 32'(status), 32'h0);
    chk("rst_out_idle_count", 32'(op_count), 32'h0);

    // Basic add: 0x0F + 0x01
    load_op(4'd2, 8'h0F, 8'h01, 8'h10);
    finish_op(3'd1);

    // Result held stable while the consumer stalls
    load_op(4'd3, 8'h20, 8'h08, 8'h18);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hold_dout", 32'(data_out), 32'h18);
      chk("hold_rv", 32'(result_valid), 32'h1);
      chk("hold_oe", 32'(data_oe), 32'hFF);
    end
    finish_op(3'd2);

    // start pulses while busy are dropped and flagged
    start = 1'b1;
    op_in = 4'd2;
    tick();
    start = 1'b0;
    chk("drop_sel0", 32'(alu_sel), 32'h2);
    data_valid = 1'b1;
    data_in    = 8'h40;
    tick();
    data_valid = 1'b0;
    chk("drop_alu_a", 32'(alu_a), 32'h40);
    start = 1'b1;
    op_in = 4'd5;
    tick();
    start = 1'b0;
    chk("drop_ldb_status", 32'(status), 32'hA);
    chk("drop_ldb_sel", 32'(alu_sel), 32'h2);
    data_valid = 1'b1;
    data_in    = 8'h02;
    tick();
    data_valid = 1'b0;
    chk("drop_alu_b", 32'(alu_b), 32'h02);
    tick();
    chk("drop_dout", 32'(data_out), 32'h42);
    start = 1'b1;
    op_in = 4'd7;
    tick();
    start = 1'b0;
    chk("drop_out_status", 32'(status), 32'hE);
    chk("drop_out_sel", 32'(alu_sel), 32'h2);
    finish_op(3'd3);
    chk("drop_sticky", 32'(status), 32'h8);
    load_op(4'd2, 8'h01, 8'h02, 8'h03);
    finish_op(3'd4);

    // Timeout in LOAD_A with no operand
    start = 1'b1;
    op_in = 4'd1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    chk("to_still_busy", 32'(status), 32'h2);
    tick();
    chk("to_status", 32'(status), 32'h1);
    chk("to_alu_a_kept", 32'(alu_a), 32'h01);
    chk("to_alu_b_kept", 32'(alu_b), 32'h02);
    chk("to_sel", 32'(alu_sel), 32'h1);
    chk("to_count", 32'(op_count), 32'h4);

    // Operand arriving in the timeout cycle wins
    start = 1'b1;
    op_in = 4'd1;
    tick();
    start = 1'b0;
    chk("to_clear", 32'(status), 32'h2);
    tick();
    tick();
    tick();
    data_valid = 1'b1;
    data_in    = 8'h0C;
    tick();
    data_valid = 1'b0;
    chk("to_win_a", 32'(alu_a), 32'h0C);
    chk("to_win_status", 32'(status), 32'h2);
    data_valid = 1'b1;
    data_in    = 8'h30;
    tick();
    data_valid = 1'b0;
    tick();
    chk("to_win_dout", 32'(data_out), 32'h3C);
    finish_op(3'd5);

    // Eight back-to-back operations wrap op_count
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("b2b_count0", 32'(op_count), 32'h0);
    for (int i = 0; i < 8; i++) begin
      load_op(t_op[i], t_a[i], t_b[i], t_y[i]);
      finish_op(3'(i + 1));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
